// File: rtl/timer_us.sv
// Microsecond down-counter timer with a four-register write/read map, a sticky done flag and a level irq.
// Define TIMER_AUTORELOAD_EN to implement the periodic (auto-reload) CTRL bit; otherwise the timer is one-shot only.
module timer_us (
   input  logic        f_in,
   input  logic        reset,
   input  logic        tick,
   input  logic        wr_en,
   input  logic [1:0]  wr_addr,
   input  logic [31:0] wr_data,
   input  logic [1:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic        irq
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [1:0] ADDR_LOAD   = 2'd0;
   localparam logic [1:0] ADDR_CTRL   = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   state_t      r_state;
   state_t      w_stateNext;
   logic [31:0] r_load;
   logic [31:0] r_count;
   logic [31:0] w_countNext;
   logic        r_irqEn;
   logic        r_done;
   logic        w_doneNext;
   logic        w_periodic;
   logic        w_running;
   logic        w_loadWr;
   logic        w_ctrlWr;
   logic        w_statusWr;
   logic        w_start;
   logic        w_stop;
   logic        w_expire;

   assign w_loadWr   = wr_en && (wr_addr == ADDR_LOAD);
   assign w_ctrlWr   = wr_en && (wr_addr == ADDR_CTRL);
   assign w_statusWr = wr_en && (wr_addr == ADDR_STATUS);
   assign w_start    = w_ctrlWr && wr_data[0];
   assign w_stop     = w_ctrlWr && wr_data[1];
   assign w_running  = (r_state == RUN);

`ifdef TIMER_AUTORELOAD_EN
   logic r_periodic;

   always_ff @(posedge f_in) begin
      if (reset) begin
         r_periodic <= 1'b0;
      end else if (w_ctrlWr) begin
         r_periodic <= wr_data[2];
      end
   end

   assign w_periodic = r_periodic;
`else
   assign w_periodic = 1'b0;
`endif

   // Stop beats start, a (re)start swallows that cycle's tick, and an expiry coinciding with stop still flags done.
   always_comb begin
      w_stateNext = r_state;
      w_countNext = r_count;
      w_expire    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start && !w_stop) begin
               w_stateNext = RUN;
               w_countNext = r_load;
            end
         end
         RUN: begin
            if (w_stop) begin
               w_stateNext = IDLE;
               w_expire    = tick && (r_count == 32'd0);
            end else if (w_start) begin
               w_countNext = r_load;
            end else if (tick) begin
               if (r_count == 32'd0) begin
                  w_expire = 1'b1;
                  if (w_periodic) begin
                     w_countNext = r_load;
                  end else begin
                     w_stateNext = IDLE;
                  end
               end else begin
                  w_countNext = r_count - 32'd1;
               end
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
      w_doneNext = (r_done && !(w_statusWr && wr_data[0])) || w_expire;
   end

   always_ff @(posedge f_in) begin
      if (reset) begin
         r_state <= IDLE;
         r_load  <= 32'd0;
         r_count <= 32'd0;
         r_irqEn <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_count <= w_countNext;
         r_done  <= w_doneNext;
         if (w_loadWr) begin
            r_load <= wr_data;
         end
         if (w_ctrlWr) begin
            r_irqEn <= wr_data[3];
         end
      end
   end

   always_comb begin
      rd_data = 32'd0;
      case (rd_addr)
         ADDR_LOAD:   rd_data = r_load;
         ADDR_CTRL:   rd_data = {28'd0, r_irqEn, w_periodic, 2'b00};
         ADDR_COUNT:  rd_data = r_count;
         ADDR_STATUS: rd_data = {30'd0, w_running, r_done};
         default:     rd_data = 32'd0;
      endcase
   end

   assign irq = r_done && r_irqEn;

endmodule

// File: tb/tb_timer_us.sv
// Testbench for timer_us: directed scenarios followed by random traffic, each cycle compared against a rule-level model.
module tb_timer_us;

`ifdef TIMER_AUTORELOAD_EN
   localparam bit kPeriodicImpl = 1'b1;
`else
   localparam bit kPeriodicImpl = 1'b0;
`endif

   logic        f_in = 1'b0;
   logic        reset;
   logic        tick;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [31:0] wr_data;
   logic [1:0]  rd_addr;
   logic [31:0] rd_data;
   logic        irq;

   int checks    = 0;
   int passCount = 0;
   int failCount = 0;

   // Abstract timer state: remaining microseconds, whether it is counting, and the flags.
   longint      mLoad;
   longint      mCount;
   bit          mRunning;
   bit          mPeriodic;
   bit          mIrqEn;
   bit          mDone;

   timer_us dut (
      .f_in    (f_in),
      .reset   (reset),
      .tick    (tick),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .irq     (irq)
   );

   always #10 f_in = ~f_in;

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   task automatic readReg(input logic [1:0] a, output logic [31:0] d);
      rd_addr = a;
      #1;
      d = rd_data;
   endtask

   task automatic checkReg(input string tag, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] d;
      readReg(a, d);
      checkEq(tag, d, exp);
   endtask

   // One clock of the model, phrased as the timer's behavioural rules rather than a state machine.
   task automatic modelStep(input bit rst, input bit we, input logic [1:0] wa,
                            input logic [31:0] wd, input bit tk);
      bit isCtrl, start, stop, clearReq, expired;
      if (rst) begin
         mLoad = 0; mCount = 0; mRunning = 0; mPeriodic = 0; mIrqEn = 0; mDone = 0;
         return;
      end
      isCtrl   = we && (wa == 2'd1);
      start    = isCtrl && wd[0];
      stop     = isCtrl && wd[1];
      clearReq = we && (wa == 2'd3) && wd[0];
      expired  = 0;
      if (mRunning && stop) begin
         expired  = tk && (mCount == 0);
         mRunning = 0;
      end else if (start && !stop) begin
         mCount   = mLoad;
         mRunning = 1;
      end else if (mRunning && tk) begin
         if (mCount > 0) begin
            mCount = mCount - 1;
         end else begin
            expired = 1;
            if (mPeriodic) mCount = mLoad;
            else           mRunning = 0;
         end
      end
      mDone = (mDone && !clearReq) || expired;
      if (we && wa == 2'd0) mLoad = wd;
      if (isCtrl) begin
         mIrqEn    = wd[3];
         mPeriodic = kPeriodicImpl && wd[2];
      end
   endtask

   task automatic checkOutput();
      checkReg("rd_load",   2'd0, mLoad[31:0]);
      checkReg("rd_ctrl",   2'd1, {28'd0, mIrqEn, mPeriodic, 2'b00});
      checkReg("rd_count",  2'd2, mCount[31:0]);
      checkReg("rd_status", 2'd3, {30'd0, mRunning, mDone});
      checkEq("irq", {31'd0, irq}, {31'd0, mDone && mIrqEn});
   endtask

   task automatic applyStimulus(input bit rst, input bit we, input logic [1:0] wa,
                                input logic [31:0] wd, input bit tk);
      reset   = rst;
      wr_en   = we;
      wr_addr = wa;
      wr_data = wd;
      tick    = tk;
      @(posedge f_in);
      modelStep(rst, we, wa, wd, tk);
      #1;
      reset = 0; wr_en = 0; tick = 0; wr_addr = 2'd0; wr_data = 32'd0;
      checkOutput();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 2'd0, 32'd0, 0);
   endtask

   task automatic pulseTick(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 2'd0, 32'd0, 1);
   endtask

   task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
      applyStimulus(0, 1, a, d, 0);
   endtask

   initial begin
      reset = 1; tick = 0; wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
      mLoad = 0; mCount = 0; mRunning = 0; mPeriodic = 0; mIrqEn = 0; mDone = 0;

      applyStimulus(1, 0, 2'd0, 32'd0, 0);
      applyStimulus(1, 0, 2'd0, 32'd0, 1);
      checkReg("reset_status", 2'd3, 32'd0);
      checkReg("reset_count",  2'd2, 32'd0);

      // LOAD=3 one-shot, tick every 50 cycles: expires on the 4th tick.
      writeReg(2'd0, 32'd3);
      writeReg(2'd1, 32'h1);
      for (int k = 0; k < 4; k++) begin
         idle(49);
         pulseTick(1);
      end
      checkReg("oneshot_status", 2'd3, 32'h1);
      checkReg("oneshot_count",  2'd2, 32'd0);

      // LOAD=0 with irq enabled: first tick expires, STATUS clear drops irq.
      writeReg(2'd3, 32'h1);
      writeReg(2'd0, 32'd0);
      writeReg(2'd1, 32'h9);
      checkEq("irq_before_tick", {31'd0, irq}, 32'd0);
      pulseTick(1);
      checkEq("irq_after_tick", {31'd0, irq}, 32'd1);
      writeReg(2'd3, 32'h1);
      checkEq("irq_after_clear", {31'd0, irq}, 32'd0);

      // LOAD=10, 4 ticks, stop: COUNT frozen at 6; start+stop together stays idle.
      writeReg(2'd1, 32'h0);
      writeReg(2'd0, 32'd10);
      writeReg(2'd1, 32'h1);
      pulseTick(4);
      writeReg(2'd1, 32'h2);
      checkReg("stop_status", 2'd3, 32'h0);
      checkReg("stop_count",  2'd2, 32'd6);
      pulseTick(3);
      checkReg("stop_count_held", 2'd2, 32'd6);
      writeReg(2'd1, 32'h3);
      checkReg("startstop_status", 2'd3, 32'h0);

      // Reset mid-run with tick and wr_en asserted.
      writeReg(2'd0, 32'd5);
      writeReg(2'd1, 32'h1);
      pulseTick(2);
      applyStimulus(1, 1, 2'd1, 32'h9, 1);
      checkReg("midrun_rst_load",   2'd0, 32'd0);
      checkReg("midrun_rst_ctrl",   2'd1, 32'd0);
      checkReg("midrun_rst_count",  2'd2, 32'd0);
      checkReg("midrun_rst_status", 2'd3, 32'd0);
      checkEq("midrun_rst_irq", {31'd0, irq}, 32'd0);

      // Start coincident with tick loads without decrement; LOAD rewrite mid-run is deferred.
      writeReg(2'd0, 32'd7);
      applyStimulus(0, 1, 2'd1, 32'h1, 1);
      checkReg("start_tick_count", 2'd2, 32'd7);
      pulseTick(1);
      writeReg(2'd0, 32'd20);
      checkReg("load_midrun_count", 2'd2, 32'd6);
      pulseTick(1);
      writeReg(2'd2, 32'hDEAD_BEEF);
      checkReg("count_write_ignored", 2'd2, 32'd5);
      writeReg(2'd1, 32'h1);
      checkReg("restart_count", 2'd2, 32'd20);
      writeReg(2'd1, 32'h2);

      // Periodic request: reloads when implemented, otherwise one-shot with the bit reading 0.
      writeReg(2'd3, 32'h1);
      writeReg(2'd0, 32'd2);
      writeReg(2'd1, 32'h5);
      pulseTick(3);
`ifdef TIMER_AUTORELOAD_EN
      checkReg("periodic_status", 2'd3, 32'h3);
      checkReg("periodic_count",  2'd2, 32'd2);
      writeReg(2'd3, 32'h1);
      pulseTick(2);
      applyStimulus(0, 1, 2'd3, 32'h1, 1);
      checkReg("clear_vs_expire", 2'd3, 32'h3);
`else
      checkReg("oneshot_only_status", 2'd3, 32'h1);
      checkReg("oneshot_only_ctrl",   2'd1, 32'h0);
`endif
      writeReg(2'd1, 32'h2);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         bit          rst, we, tk;
         logic [1:0]  wa;
         logic [31:0] wd;
         rst = ($urandom_range(0, 199) == 0);
         tk  = ($urandom_range(0, 3) == 0);
         we  = ($urandom_range(0, 4) == 0);
         wa  = 2'($urandom_range(0, 3));
         wd  = (wa == 2'd0) ? 32'($urandom_range(0, 6)) : $urandom;
         applyStimulus(rst, we, wa, wd, tk);
      end

      $display("[TB] %0d/%0d checks passed", passCount, checks);
      $finish;
   end

endmodule
